smi_rx_channel_arbiter: RTL
===========================

Name: smi_rx_channel_arbiter

Overview:
Shares the single 32-bit SMI RX FIFO (pulled by the SMI read path) between the two per-radio IQ sample FIFOs, channel 0 (sub-GHz) and channel 1 (2.4 GHz). It runs a round-robin burst scheduler when both channels are enabled and forwards one channel exclusively when only that channel is enabled. It drains the FIFOs of disabled channels so they never stall, and it keeps per-channel word and drop statistics for the ioc register file. It sits on i_sys_clk between the LVDS deserializer FIFOs and the SMI RX FIFO push port.

Parameters:
BURST_LEN, 16, maximum words forwarded from one channel per grant before re-arbitration (range 1..255)
CNT_W, 16, width of each statistics counter

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge
i_rst_b  in  1  synchronous reset, active low
i_ch_en  in  2  channel enable; bit n enables channel n
i_tag_en  in  1  when 1, bit 0 of every forwarded word is replaced by the source channel id
i_stats_clr  in  1  single-cycle synchronous clear of all statistics counters
o_ch0_pull  out  1  pull strobe to channel 0 source FIFO
i_ch0_data  in  32  channel 0 FIFO read data; valid the cycle after the pull
i_ch0_empty  in  1  channel 0 FIFO empty
o_ch1_pull  out  1  pull strobe to channel 1 source FIFO
i_ch1_data  in  32  channel 1 FIFO read data; valid the cycle after the pull
i_ch1_empty  in  1  channel 1 FIFO empty
o_rx_fifo_push  out  1  push strobe to the SMI RX FIFO
o_rx_fifo_data  out  32  word pushed to the SMI RX FIFO
i_rx_fifo_full  in  1  SMI RX FIFO full
o_grant  out  1  channel currently or last granted
o_busy  out  1  high in any state other than S_IDLE
o_ch0_count  out  CNT_W  words forwarded from channel 0, saturating
o_ch1_count  out  CNT_W  words forwarded from channel 1, saturating
o_drop_count  out  CNT_W  words drained from disabled channels, saturating

Behaviour:
- Reset (i_rst_b=0 at a clock edge): state S_IDLE; all pull and push strobes 0; o_rx_fifo_data 0; o_grant 0; burst counter 0; all counters 0. Reset mid-transfer abandons the held word and does not push it.
- State S_IDLE (arbitration):
  - Candidate channel n is one that is enabled and has !empty.
  - If both channels are candidates, pick the channel other than o_grant when the last burst ended. Otherwise pick the only candidate.
  - Start only if !i_rx_fifo_full. On start: assert the pull for exactly 1 cycle, set o_grant, clear the burst counter, go to S_FETCH.
  - Otherwise, if a disabled channel is !empty, assert its pull for 1 cycle and go to S_DRAIN. When both channels are disabled and non-empty, the lower channel index is drained first.
  - Forwarding always has priority over draining.
- S_FETCH (1 cycle): capture the granted channel's data into the hold register, applying the tag if i_tag_en. Go to S_PUSH.
- S_PUSH:
  - While i_rx_fifo_full=1: hold; o_rx_fifo_data stays stable; o_rx_fifo_push stays 0.
  - When !full: assert o_rx_fifo_push for 1 cycle with the hold data, increment the granted channel's counter and the burst counter.
  - Then, if the burst counter has reached BURST_LEN, or the granted channel is empty, or the granted channel is now disabled: go to S_IDLE to re-arbitrate.
  - Otherwise pull the same channel again and go to S_FETCH.
- S_DRAIN (1 cycle): discard the data, increment o_drop_count, go to S_IDLE.
- Throughput and latency:
  - Steady state is 1 word per 2 cycles within a burst.
  - Latency from pull to push is 2 cycles when the destination is not full.
- Pull rules:
  - At most one pull strobe is high in any cycle.
  - A pull is never issued to an empty FIFO.
  - A pull is never issued while the hold register is occupied.
- i_ch_en changes take effect at the next S_IDLE or burst check. An in-flight word is always pushed, never dropped.
- Tag: o_rx_fifo_data[0] = channel id when i_tag_en=1; otherwise the data passes unchanged. i_tag_en is sampled in S_FETCH.
- Counters:
  - Saturate at all ones.
  - i_stats_clr has priority over an increment in the same cycle; the result is 0.

Decomposition:
- Shared package smi_pkg holds:
  - state encoding: S_IDLE=2'b00, S_FETCH=2'b01, S_PUSH=2'b10, S_DRAIN=2'b11
  - channel id constants CH_0=1'b0, CH_1=1'b1
  - default BURST_LEN
- One sub-module is natural: sat_counter (parameterised width, inc, clr, saturation), instantiated three times.

Test Plan:
- Both channels enabled, each holds 40 words, BURST_LEN=16, destination never full -> push order is 16 ch0, 16 ch1, 16 ch0, 16 ch1, 8 ch0, 8 ch1; o_ch0_count=o_ch1_count=40.
- i_ch_en=2'b01, ch1 holds 5 words, ch0 holds 3 words -> 3 ch0 words pushed first, then 5 ch1 pulls with no push; o_drop_count=5.
- Hold i_rx_fifo_full=1 for 10 cycles during S_PUSH -> o_rx_fifo_data stable, no push, no new pull; exactly one push once full drops.
- i_tag_en=1, ch1 word 32'hFFFF_FFFE -> pushed 32'hFFFF_FFFF; ch0 word 32'h0000_0001 -> pushed 32'h0000_0000.
- Preload o_ch0_count to 16'hFFFF by forwarding 65535 words, then forward 1 more -> stays 16'hFFFF; pulse i_stats_clr in the same cycle as a push -> 0.
- Assert i_rst_b=0 in S_PUSH -> next cycle state S_IDLE, no push, all counters 0, o_grant 0.

Source files
------------

// File: rtl/smi_pkg.sv
// Shared definitions for the SMI RX channel arbiter: FSM encoding, channel ids,
// default burst length and the channel-tag helper.
package smi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_PUSH  = 2'b10,
    S_DRAIN = 2'b11
  } state_t;

  localparam logic CH_0 = 1'b0;
  localparam logic CH_1 = 1'b1;

  localparam int BURST_LEN_DEF = 16;
  localparam int BURST_W       = 8;

  // Bit 0 of a forwarded word carries the source channel id when tagging is on.
  function automatic logic [31:0] apply_tag(input logic [31:0] data,
                                            input logic        tag_en,
                                            input logic        ch);
    return tag_en ? {data[31:1], ch} : data;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_sys_clk,
  input  logic         i_rst_b,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/smi_rx_channel_arbiter.sv
// Round-robin burst arbiter feeding the shared SMI RX FIFO from two per-radio
// IQ FIFOs, draining disabled channels and keeping per-channel statistics.
module smi_rx_channel_arbiter
  import smi_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_b,
  input  logic [1:0]       i_ch_en,
  input  logic             i_tag_en,
  input  logic             i_stats_clr,
  output logic             o_ch0_pull,
  input  logic [31:0]      i_ch0_data,
  input  logic             i_ch0_empty,
  output logic             o_ch1_pull,
  input  logic [31:0]      i_ch1_data,
  input  logic             i_ch1_empty,
  output logic             o_rx_fifo_push,
  output logic [31:0]      o_rx_fifo_data,
  input  logic             i_rx_fifo_full,
  output logic             o_grant,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_ch0_count,
  output logic [CNT_W-1:0] o_ch1_count,
  output logic [CNT_W-1:0] o_drop_count
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN);

  state_t             state, state_nxt;
  logic               grant_nxt;
  logic               have_last, have_last_nxt;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [31:0]        hold_nxt;
  logic [1:0]         cand, drain_req, pull;
  logic               pick, push;
  logic               ch0_inc, ch1_inc, drop_inc;
  logic               gnt_empty, gnt_en;

  assign cand      =  i_ch_en & ~{i_ch1_empty, i_ch0_empty};
  assign drain_req = ~i_ch_en & ~{i_ch1_empty, i_ch0_empty};
  assign gnt_empty = (o_grant == CH_1) ? i_ch1_empty : i_ch0_empty;
  assign gnt_en    = i_ch_en[o_grant];

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = o_grant;
    have_last_nxt = have_last;
    burst_cnt_nxt = burst_cnt;
    hold_nxt      = o_rx_fifo_data;
    pull          = 2'b00;
    pick          = CH_0;
    push          = 1'b0;
    ch0_inc       = 1'b0;
    ch1_inc       = 1'b0;
    drop_inc      = 1'b0;

    case (state)
      S_IDLE: begin
        if ((cand != 2'b00) && !i_rx_fifo_full) begin
          // Until a first burst has ended there is no previous grant to alternate from.
          if (cand == 2'b11) pick = have_last ? ~o_grant : CH_0;
          else               pick = cand[1] ? CH_1 : CH_0;
          pull[pick]    = 1'b1;
          grant_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = S_FETCH;
        end else if (drain_req[0]) begin
          pull[0]   = 1'b1;
          state_nxt = S_DRAIN;
        end else if (drain_req[1]) begin
          pull[1]   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end

      S_FETCH: begin
        hold_nxt  = apply_tag((o_grant == CH_1) ? i_ch1_data : i_ch0_data, i_tag_en, o_grant);
        state_nxt = S_PUSH;
      end

      S_PUSH: begin
        if (!i_rx_fifo_full) begin
          push          = 1'b1;
          burst_cnt_nxt = burst_cnt + 1'b1;
          ch0_inc       = (o_grant == CH_0);
          ch1_inc       = (o_grant == CH_1);
          if ((burst_cnt_nxt >= BURST_MAX) || gnt_empty || !gnt_en) begin
            have_last_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end else begin
            // The hold register empties this cycle, so the next word can be requested now.
            pull[o_grant] = 1'b1;
            state_nxt     = S_FETCH;
          end
        end
      end

      S_DRAIN: begin
        drop_inc  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      state          <= S_IDLE;
      o_grant        <= CH_0;
      have_last      <= 1'b0;
      burst_cnt      <= '0;
      o_rx_fifo_data <= '0;
    end else begin
      state          <= state_nxt;
      o_grant        <= grant_nxt;
      have_last      <= have_last_nxt;
      burst_cnt      <= burst_cnt_nxt;
      o_rx_fifo_data <= hold_nxt;
    end
  end

  // Strobes are decoded from state and inputs, so they are masked while reset is held.
  assign o_ch0_pull     = pull[0] & i_rst_b;
  assign o_ch1_pull     = pull[1] & i_rst_b;
  assign o_rx_fifo_push = push & i_rst_b;
  assign o_busy         = (state != S_IDLE);

  sat_counter #(.W(CNT_W)) u_ch0_cnt (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .inc       (ch0_inc),
    .clr       (i_stats_clr),
    .count     (o_ch0_count)
  );

  sat_counter #(.W(CNT_W)) u_ch1_cnt (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .inc       (ch1_inc),
    .clr       (i_stats_clr),
    .count     (o_ch1_count)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .i_sys_clk (i_sys_clk),
    .i_rst_b   (i_rst_b),
    .inc       (drop_inc),
    .clr       (i_stats_clr),
    .count     (o_drop_count)
  );

endmodule
